uart_echo_ctrl: RTL and testbench

Byte-level echo controller on the user side of the UART core: consumes received bytes (`rx_data`/`rx_done`), buffers them in a small FIFO, and replays each one to the transmitter (`tx_data`/`tx_start`) when `tx_busy` permits. Optionally folds ASCII lowercase to uppercase. Sits between the UART core and the board top as the host-facing loopback and terminal-echo path.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_echo_ctrl_if.sv | 28 ++
 rtl/sync_fifo.sv | 64 ++++++
 rtl/uart_echo_ctrl.sv | 87 ++++++++
 tb/tb_uart_echo_ctrl.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART echo path.
// Contents: echo FSM state enum, ASCII case-folding constants and a helper
// that folds one lowercase ASCII letter to uppercase.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BUSY,
    WAIT_DONE
  } echo_state_t;

  localparam logic [7:0] ASCII_LC_A     = 8'h61;
  localparam logic [7:0] ASCII_LC_Z     = 8'h7A;
  localparam logic [7:0] ASCII_CASE_OFS = 8'h20;

  // 'a'..'z' -> 'A'..'Z', everything else unchanged.
  function automatic logic [7:0] fold_upper(input logic [7:0] b);
    if (b >= ASCII_LC_A && b <= ASCII_LC_Z) begin
      return b - ASCII_CASE_OFS;
    end
    return b;
  endfunction

endpackage

// File: rtl/uart_echo_ctrl_if.sv
// Byte-level link between the UART core and the echo controller.
// Signals: rx_data/rx_done (received byte + one-cycle strobe), tx_busy (transmitter
// busy level), tx_start/tx_data (launch pulse + byte), fifo_count (occupancy),
// overflow (dropped-byte pulse).
// Modports: master = echo controller side, slave = UART core / environment side.
interface uart_echo_ctrl_if #(
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic [7:0]      rx_data;
  logic            rx_done;
  logic            tx_busy;
  logic            tx_start;
  logic [7:0]      tx_data;
  logic [CntW-1:0] fifo_count;
  logic            overflow;

  modport master (
    input  rx_data, rx_done, tx_busy,
    output tx_start, tx_data, fifo_count, overflow
  );

  modport slave (
    output rx_data, rx_done, tx_busy,
    input  tx_start, tx_data, fifo_count, overflow
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead head output.
// Ports: clk, rst (async, active low); push/din write side; pop read side;
// dout = current head; count = occupancy 0..DEPTH; full/empty flags;
// drop = combinational flag for a push refused because the FIFO is full.
// A push while full is still accepted if a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CntW-1:0]  count,
  output logic             full,
  output logic             empty,
  output logic             drop
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_ok, do_pop;

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  assign push_ok = push && (!full || do_pop);
  assign drop    = push && !push_ok;
  assign dout    = mem[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    count_d = count_q;
    unique case ({push_ok, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/uart_echo_ctrl.sv
// Echo controller: buffers received bytes and replays each one to the UART
// transmitter, optionally folding ASCII lowercase to uppercase.
// Ports: clk; rst (async, active low); bus (master modport) carrying
// rx_data/rx_done in, tx_busy in, tx_start/tx_data out, fifo_count out,
// overflow out. All outputs are registered.
module uart_echo_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter bit          UPPERCASE = 1'b1
) (
  input logic                clk,
  input logic                rst,
  uart_echo_ctrl_if.master   bus
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  echo_state_t     state_q, state_d;
  logic            tx_start_q, tx_start_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            overflow_q;
  logic            pop;
  logic [7:0]      head;
  logic [CntW-1:0] count;
  logic            full, empty, drop;

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (bus.rx_done),
    .din  (bus.rx_data),
    .pop  (pop),
    .dout (head),
    .count(count),
    .full (full),
    .empty(empty),
    .drop (drop)
  );

  // A launch needs a full busy-high then busy-low cycle before the next one.
  always_comb begin
    state_d    = state_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    pop        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty && !bus.tx_busy) begin
          tx_data_d  = UPPERCASE ? fold_upper(head) : head;
          tx_start_d = 1'b1;
          pop        = 1'b1;
          state_d    = WAIT_BUSY;
        end
      end
      WAIT_BUSY: if (bus.tx_busy)  state_d = WAIT_DONE;
      WAIT_DONE: if (!bus.tx_busy) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      overflow_q <= drop;
    end
  end

  assign bus.tx_start   = tx_start_q;
  assign bus.tx_data    = tx_data_q;
  assign bus.fifo_count = count;
  assign bus.overflow   = overflow_q;

  logic unused_full;
  assign unused_full = full;

endmodule

// File: tb/tb_uart_echo_ctrl.sv
module tb_uart_echo_ctrl;

  localparam int BusyLen = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       tx_busy;

  int n_checks = 0;
  int n_errors = 0;

  bit         busy_hold = 1'b0;
  int         busy_cnt = 0;
  logic [7:0] q_up[$];
  logic [7:0] q_raw[$];
  int         ovf_pulses = 0;
  int         back_to_back = 0;
  logic       prev_start = 1'b0;

  uart_echo_ctrl_if #(.DEPTH(8)) bus_up ();
  uart_echo_ctrl_if #(.DEPTH(8)) bus_raw ();

  assign bus_up.rx_data  = rx_data;
  assign bus_up.rx_done  = rx_done;
  assign bus_up.tx_busy  = tx_busy;
  assign bus_raw.rx_data = rx_data;
  assign bus_raw.rx_done = rx_done;
  assign bus_raw.tx_busy = tx_busy;

  uart_echo_ctrl #(.DEPTH(8), .UPPERCASE(1'b1)) u_dut_up (
    .clk(clk),
    .rst(rst),
    .bus(bus_up.master)
  );

  uart_echo_ctrl #(.DEPTH(8), .UPPERCASE(1'b0)) u_dut_raw (
    .clk(clk),
    .rst(rst),
    .bus(bus_raw.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Transmitter model: busy for BusyLen cycles starting the cycle after tx_start,
  // or forced high while busy_hold is set.
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (busy_cnt > 0) begin
        tx_busy = 1'b1;
        busy_cnt--;
      end else begin
        tx_busy = busy_hold;
      end
      if (bus_up.tx_start === 1'b1) busy_cnt = BusyLen;
    end
  end

  // Launch / overflow monitor.
  always @(negedge clk) begin
    if (bus_up.tx_start === 1'b1) begin
      q_up.push_back(bus_up.tx_data);
      q_raw.push_back(bus_raw.tx_data);
      if (prev_start) back_to_back++;
    end
    prev_start = (bus_up.tx_start === 1'b1);
    if (bus_up.overflow === 1'b1) ovf_pulses++;
  end

  task automatic send(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_data = b;
    rx_done = 1'b1;
    @(posedge clk);
    #1;
    rx_done = 1'b0;
  endtask

  task automatic wait_launches(input string tag, input int n);
    for (int i = 0; i < 1000 && q_up.size() < n; i++) @(negedge clk);
    check(tag, 32'(q_up.size()), 32'(n));
  endtask

  task automatic wait_quiet(input string tag);
    for (int i = 0; i < 1000 && !(busy_cnt == 0 && tx_busy == 1'b0 &&
         bus_up.fifo_count == 4'd0); i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check(tag, 32'(busy_cnt == 0 && tx_busy == 1'b0 && bus_up.fifo_count == 4'd0), 32'd1);
  endtask

  task automatic clear_log();
    q_up.delete();
    q_raw.delete();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] exp_raw [3];
    logic [7:0] exp_up [3];
    exp_raw = '{8'h61, 8'h7B, 8'h40};
    exp_up  = '{8'h41, 8'h7B, 8'h40};

    rst     = 1'b0;
    rx_data = 8'h00;
    rx_done = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx_start", 32'(bus_up.tx_start), 32'd0);
    check("rst_tx_data", 32'(bus_up.tx_data), 32'h00);
    check("rst_count", 32'(bus_up.fifo_count), 32'd0);
    check("rst_overflow", 32'(bus_up.overflow), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);

    // Single byte with latency: rx in k, count=1 in k+1, launch in k+2
    clear_log();
    @(posedge clk);
    #1;
    rx_data = 8'h61;
    rx_done = 1'b1;
    @(negedge clk);
    check("lat_k_start", 32'(bus_up.tx_start), 32'd0);
    @(posedge clk);
    #1 rx_done = 1'b0;
    @(negedge clk);
    check("lat_k1_count", 32'(bus_up.fifo_count), 32'd1);
    check("lat_k1_start", 32'(bus_up.tx_start), 32'd0);
    @(negedge clk);
    check("lat_k2_start", 32'(bus_up.tx_start), 32'd1);
    check("lat_k2_data_up", 32'(bus_up.tx_data), 32'h41);
    check("lat_k2_data_raw", 32'(bus_raw.tx_data), 32'h61);
    check("lat_k2_count", 32'(bus_up.fifo_count), 32'd0);
    @(negedge clk);
    check("single_no_repeat", 32'(bus_up.tx_start), 32'd0);
    wait_quiet("single_quiet");
    check("single_launches", 32'(q_up.size()), 32'd1);

    // Passthrough vs fold
    clear_log();
    send(8'h61);
    send(8'h7B);
    send(8'h40);
    wait_launches("pass_launches", 3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("pass_raw_%0d", i), 32'(q_raw[i]), 32'(exp_raw[i]));
      check($sformatf("pass_up_%0d", i), 32'(q_up[i]), 32'(exp_up[i]));
    end
    wait_quiet("pass_quiet");

    // Burst under backpressure
    clear_log();
    busy_hold = 1'b1;
    for (int i = 0; i < 8; i++) send(8'h30 + 8'(i));
    @(negedge clk);
    check("burst_count", 32'(bus_up.fifo_count), 32'd8);
    check("burst_no_launch", 32'(q_up.size()), 32'd0);

    // Overflow while full
    ovf_pulses = 0;
    @(posedge clk);
    #1;
    rx_data = 8'h55;
    rx_done = 1'b1;
    @(negedge clk);
    check("ovf_k", 32'(bus_up.overflow), 32'd0);
    @(posedge clk);
    #1 rx_done = 1'b0;
    @(negedge clk);
    check("ovf_k1", 32'(bus_up.overflow), 32'd1);
    check("ovf_count", 32'(bus_up.fifo_count), 32'd8);
    @(negedge clk);
    check("ovf_k2", 32'(bus_up.overflow), 32'd0);
    check("ovf_pulses", 32'(ovf_pulses), 32'd1);

    // Release busy and push in the very launch cycle with count=8
    @(posedge clk);
    #1;
    busy_hold = 1'b0;
    tx_busy   = 1'b0;
    rx_data   = 8'h38;
    rx_done   = 1'b1;
    @(posedge clk);
    #1 rx_done = 1'b0;
    @(negedge clk);
    check("simul_start", 32'(bus_up.tx_start), 32'd1);
    check("simul_data", 32'(bus_up.tx_data), 32'h30);
    check("simul_count", 32'(bus_up.fifo_count), 32'd8);
    check("simul_no_ovf", 32'(bus_up.overflow), 32'd0);
    wait_launches("burst_launches", 9);
    for (int i = 0; i < 9; i++) begin
      check($sformatf("burst_order_%0d", i), 32'(q_up[i]), 32'h30 + 32'(i));
    end
    check("burst_ovf_total", 32'(ovf_pulses), 32'd1);
    wait_quiet("burst_quiet");
    check("burst_total", 32'(q_up.size()), 32'd9);

    // Reset in WAIT_DONE with three bytes queued
    clear_log();
    send(8'h41);
    send(8'h42);
    send(8'h43);
    send(8'h44);
    repeat (3) @(negedge clk);
    check("pre_rst_count", 32'(bus_up.fifo_count), 32'd3);
    check("pre_rst_data", 32'(bus_up.tx_data), 32'h41);
    rst = 1'b0;
    #1;
    check("mid_rst_count", 32'(bus_up.fifo_count), 32'd0);
    check("mid_rst_start", 32'(bus_up.tx_start), 32'd0);
    check("mid_rst_data", 32'(bus_up.tx_data), 32'h00);
    check("mid_rst_ovf", 32'(bus_up.overflow), 32'd0);
    clear_log();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (60) @(negedge clk);
    check("post_rst_no_launch", 32'(q_up.size()), 32'd0);
    send(8'h62);
    wait_launches("post_rst_launch", 1);
    check("post_rst_up", 32'(q_up[0]), 32'h42);
    check("post_rst_raw", 32'(q_raw[0]), 32'h62);
    wait_quiet("post_rst_quiet");

    check("no_back_to_back", 32'(back_to_back), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
